// File: rtl/adc_temp_pkg.sv
// Shared constants, breakpoint table and FSM encoding for the ADC-code to
// temperature decoder.
package adc_temp_pkg;

    localparam int ADC_W      = 12;
    localparam int TEMP_W     = 12;
    localparam int CODE_MIN   = 64;
    localparam int CODE_MAX   = 4031;
    localparam int TEMP_FAULT = 2047;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MUL,
        FINAL
    } state_t;

    // NTC curve in tenths of a degree; entry 16 is the virtual breakpoint at code 4096.
    function automatic logic signed [12:0] lut(input logic [4:0] idx);
        logic signed [12:0] v;
        case (idx)
            5'd0:    v = 13'sd1250;
            5'd1:    v = 13'sd1052;
            5'd2:    v = 13'sd872;
            5'd3:    v = 13'sd757;
            5'd4:    v = 13'sd669;
            5'd5:    v = 13'sd597;
            5'd6:    v = 13'sd535;
            5'd7:    v = 13'sd479;
            5'd8:    v = 13'sd427;
            5'd9:    v = 13'sd377;
            5'd10:   v = 13'sd328;
            5'd11:   v = 13'sd278;
            5'd12:   v = 13'sd225;
            5'd13:   v = 13'sd165;
            5'd14:   v = 13'sd90;
            5'd15:   v = -13'sd15;
            default: v = -13'sd400;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/seq_mult_s13u8.sv
// Iterative signed(13) x unsigned(8) shift-add multiplier: load clears the
// accumulator, then eight cycles consume the multiplier LSB first.
module seq_mult_s13u8 (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic signed [12:0] a,
    input  logic        [7:0]  b,
    output logic signed [20:0] p,
    output logic               done
);

    logic signed [20:0] mc_q;
    logic signed [20:0] acc_q;
    logic        [7:0]  mp_q;
    logic        [3:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_q  <= '0;
            acc_q <= '0;
            mp_q  <= '0;
            cnt_q <= 4'd8;
        end else if (load) begin
            mc_q  <= {{8{a[12]}}, a};
            acc_q <= '0;
            mp_q  <= b;
            cnt_q <= 4'd0;
        end else if (!cnt_q[3]) begin
            if (mp_q[0])
                acc_q <= acc_q + mc_q;
            mc_q  <= mc_q <<< 1;
            mp_q  <= mp_q >> 1;
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign p    = acc_q;
    assign done = cnt_q[3];

endmodule

// File: rtl/adc_temp_decoder.sv
// Raw NTC ADC code -> signed temperature (0.1 degC) by LUT + linear interpolation.
// Optional out-of-range sensor detection with `define ADC_TEMP_RANGE_CHECK_EN.
module adc_temp_decoder
    import adc_temp_pkg::*;
#(
    parameter int ADC_W  = adc_temp_pkg::ADC_W,
    parameter int TEMP_W = adc_temp_pkg::TEMP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADC_W-1:0]         adc_code,
    output logic                     busy,
    output logic signed [TEMP_W-1:0] temp,
    output logic                     temp_valid,
    output logic                     sensor_fault
);

    localparam logic signed [21:0] SAT_HI = 22'((1 <<< (TEMP_W-1)) - 1);
    localparam logic signed [21:0] SAT_LO = 22'(-(1 <<< (TEMP_W-1)));

    state_t state_q, state_d;
    logic        [3:0]        k_q;
    logic        [7:0]        f_q;
    logic signed [12:0]       base_q;
    logic signed [12:0]       lo, hi, delta;
    logic signed [20:0]       prod, term;
    logic signed [21:0]       sum;
    logic signed [TEMP_W-1:0] sat, temp_q;
    logic                     valid_q, mul_load, mul_done;

    assign lo    = lut({1'b0, k_q});
    assign hi    = lut({1'b0, k_q} + 5'd1);
    assign delta = hi - lo;

    seq_mult_s13u8 u_mult (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .a    (delta),
        .b    (f_q),
        .p    (prod),
        .done (mul_done)
    );

    // Round half up: arithmetic shift floors, so the +128 bias rounds toward +inf.
    assign term = (prod + 21'sd128) >>> 8;
    assign sum  = {{9{base_q[12]}}, base_q} + {term[20], term};

    always_comb begin
        sat = sum[TEMP_W-1:0];
        if (sum > SAT_HI)
            sat = SAT_HI[TEMP_W-1:0];
        else if (sum < SAT_LO)
            sat = SAT_LO[TEMP_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = LOOKUP;
            LOOKUP: begin
                mul_load = 1'b1;
                state_d  = MUL;
            end
            MUL:     if (mul_done) state_d = FINAL;
            default: state_d = IDLE;
        endcase
    end

`ifdef ADC_TEMP_RANGE_CHECK_EN
    logic fault_q, sf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            sf_q    <= 1'b0;
        end else if (state_q == IDLE && start) begin
            fault_q <= (adc_code < ADC_W'(CODE_MIN)) || (adc_code > ADC_W'(CODE_MAX));
        end else if (state_q == FINAL) begin
            sf_q <= fault_q;
        end
    end

    assign sensor_fault = sf_q;
`else
    logic fault_q;

    assign fault_q      = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            f_q     <= '0;
            base_q  <= '0;
            temp_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    k_q <= adc_code[11:8];
                    f_q <= adc_code[7:0];
                end
                LOOKUP: base_q <= lo;
                FINAL: begin
                    temp_q  <= fault_q ? TEMP_W'(TEMP_FAULT) : sat;
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign temp       = temp_q;
    assign temp_valid = valid_q;

endmodule

// File: tb/tb_adc_temp_decoder.sv
// Scoreboard bench for adc_temp_decoder: expectations queued on accept,
// checked on temp_valid.
module tb_adc_temp_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic        [11:0] adc_code = '0;
    logic               busy, temp_valid, sensor_fault;
    logic signed [11:0] temp;

    adc_temp_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .adc_code     (adc_code),
        .busy         (busy),
        .temp         (temp),
        .temp_valid   (temp_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int f;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0, n_valid = 0, cyc = 0;
    int   exp_temp = 0, exp_fault = 0, prev_t = 0;
    bit   sweep_on = 0, have_prev = 0;

    int ref_lut [17] = '{1250, 1052, 872, 757, 669, 597, 535, 479, 427,
                         377, 328, 278, 225, 165, 90, -15, -400};

    task automatic chk(input string tag, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, expv, $time);
        end
    endtask

    function automatic int ref_temp(input int code);
        int k, f, d, r;
        k = code / 256;
        f = code % 256;
        d = ref_lut[k+1] - ref_lut[k];
        r = ref_lut[k] + ((d * f + 128) >>> 8);
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
`ifdef ADC_TEMP_RANGE_CHECK_EN
        if (code < 64 || code > 4031) r = 2047;
`endif
        return r;
    endfunction

    function automatic int ref_fault(input int code);
`ifdef ADC_TEMP_RANGE_CHECK_EN
        return (code < 64 || code > 4031) ? 1 : 0;
`else
        return (code < 0) ? 1 : 0;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Check any completed result first, then record a start the DUT will take at the next edge.
    always @(negedge clk) begin
        if (!rst && temp_valid) begin
            n_valid++;
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("temp", int'(temp), e.t);
                chk("sensor_fault", int'(sensor_fault), e.f);
                chk("latency", cyc - e.cyc, 11);
                if (sweep_on && e.f == 0) begin
                    if (have_prev) chk("monotonic", int'(int'(temp) <= prev_t), 1);
                    prev_t    = int'(temp);
                    have_prev = 1;
                end
            end
        end
        if (!rst && start && !busy)
            q.push_back('{exp_temp, exp_fault, cyc + 1});
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    task automatic issue(input logic [11:0] c, input int et, input int ef);
        wait_idle();
        exp_temp  = et;
        exp_fault = ef;
        adc_code  = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        adc_code = 12'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int nv;

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_temp", int'(temp), 0);
        chk("rst_valid", int'(temp_valid), 0);
        chk("rst_fault", int'(sensor_fault), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Busy must stay high for exactly the 11 cycles of a conversion.
        wait_idle();
        exp_temp = 479; exp_fault = 0;
        adc_code = 12'h700; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("busy_hi", int'(busy), 1);
        end
        @(negedge clk);
        chk("busy_lo", int'(busy), 0);
        drain();

        issue(12'h780, 453, 0);
        issue(12'hFFF, -398, 0);
        issue(12'h000, 1250, 0);
        drain();

        // Reset in the middle of the multiply discards the conversion.
        issue(12'h700, 479, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        q.delete();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_temp", int'(temp), 0);
        chk("midrst_valid", int'(temp_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nv = n_valid;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_valid", n_valid - nv, 0);

        // Start held continuously: five accepts in 55 edges, none while busy.
        wait_idle();
        nv = n_valid;
        exp_temp = 453; exp_fault = 0;
        adc_code = 12'h780; start = 1'b1;
        repeat (55) @(posedge clk);
        #1 start = 1'b0;
        drain();
        chk("b2b_count", n_valid - nv, 5);

        // A start pulse during busy must be ignored.
        nv = n_valid;
        issue(12'h000, 1250, 0);
        repeat (3) @(posedge clk);
        #1 exp_temp = -398; adc_code = 12'hFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain();
        chk("busy_ignore", n_valid - nv, 1);

`ifdef ADC_TEMP_RANGE_CHECK_EN
        issue(12'h010, 2047, 1);
`else
        issue(12'h010, 1238, 0);
`endif
        issue(12'h700, 479, 0);
        drain();

        sweep_on = 1;
        for (int c = 0; c < 4096; c++)
            issue(12'(c), ref_temp(c), ref_fault(c));
        drain();
        sweep_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
